// File: rtl/ifetch.sv
// Instruction fetch front end: PC, ROM read port and a
// two-entry {pc, data} skid buffer feeding decode.
module ifetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  typedef enum logic {
    IDLE,
    RUN
  } st_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } ent_t;

  st_t               st;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  ent_t              e0;
  ent_t              e1;
  ent_t              wr;
  logic              pop;
  logic              issue;
  logic              full;

  assign full  = (count == 2'd2);
  assign pop   = inst_valid && inst_ready && !redirect_valid;
  assign issue = rst_n && (st == RUN) && fetch_en
                 && !redirect_valid && (!full || pop);

  assign rom_addr = pc;
  assign rom_read = issue;
  assign rom_en   = issue;

  // ROM bus floats when not enabled; only pass it on when issuing.
  assign wr = issue ? {pc, rom_data} : '0;

  assign inst_valid = (count != 2'd0);
  assign inst_data  = e0.data;
  assign inst_pc    = e0.pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      pc    <= RESET_PC;
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else begin
      unique case (st)
        IDLE: if (fetch_en) st <= RUN;
        RUN:  if (!fetch_en) st <= IDLE;
        default: st <= IDLE;
      endcase
      if (redirect_valid) begin
        pc    <= redirect_pc;
        count <= 2'd0;
      end else begin
        if (issue) pc <= pc + 1'b1;
        unique case ({pop, issue})
          2'b01: begin
            if (count == 2'd0) e0 <= wr;
            else e1 <= wr;
            count <= count + 2'd1;
          end
          2'b10: begin
            e0    <= e1;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              e0 <= wr;
            end else begin
              e0 <= e1;
              e1 <= wr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: ROM returns data = address,
// expected PCs are queued and checked at each handshake.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] rom_addr;
  logic        rom_read;
  logic        rom_en;
  wire  [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;

  int ncmp = 0;
  int nbad = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  assign rom_data = (rom_en && rom_read) ? {16'h0000, rom_addr} : 'z;

  ifetch #(
    .ADDR_W(16),
    .DATA_W(32),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .rom_addr(rom_addr),
    .rom_read(rom_read),
    .rom_en(rom_en),
    .rom_data(rom_data),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [15:0] start, input int n);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      q.push_back(a);
      a = a + 16'd1;
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    inst_ready = 1'b1;
    do begin
      cyc();
      n++;
    end while (q.size() != 0 && n < bound);
    inst_ready = 1'b0;
    chk("drain_left", q.size(), 0);
  endtask

  // Every accepted instruction must be the next expected PC.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      chk("sb_has_exp", {31'd0, q.size() > 0}, 1);
      if (q.size() > 0) begin
        logic [15:0] e;
        e = q.pop_front();
        chk("inst_pc", {16'h0, inst_pc}, {16'h0, e});
        chk("inst_data", inst_data, {16'h0, e});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    inst_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_valid", {31'd0, inst_valid}, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", {16'h0, inst_pc}, 0);
    chk("rst_rom_en", {31'd0, rom_en}, 0);
    chk("rst_rom_read", {31'd0, rom_read}, 0);

    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rom_en", {31'd0, rom_en}, 0);

    // Enable and stream 0..3
    cyc();
    push_run(16'h0000, 6);
    inst_ready = 1'b1;
    fetch_en = 1'b1;
    @(negedge clk);
    chk("idle_no_issue", {31'd0, rom_en}, 0);
    cyc();
    @(negedge clk);
    chk("first_issue", {31'd0, rom_en}, 1);
    chk("first_addr", {16'h0, rom_addr}, 0);
    chk("first_nvalid", {31'd0, inst_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("stream_valid", {31'd0, inst_valid}, 1);
    end

    // Backpressure: 4 and 5 buffered, fetch stalls
    cyc();
    inst_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk);
      chk("bp_rom_en", {31'd0, rom_en}, 0);
      chk("bp_valid", {31'd0, inst_valid}, 1);
      chk("bp_data_held", inst_data, 32'd4);
      chk("bp_pc_held", {16'h0, inst_pc}, 32'd4);
    end
    cyc();
    push_run(16'h0006, 2);
    drain(20);
    repeat (2) cyc();
    @(negedge clk);
    chk("full_rom_en", {31'd0, rom_en}, 0);

    // Redirect with full buffer
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    inst_ready = 1'b1;
    q.delete();
    push_run(16'h0100, 2);
    @(negedge clk);
    chk("redir_no_issue", {31'd0, rom_en}, 0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_bubble", {31'd0, inst_valid}, 0);
    chk("redir_addr", {16'h0, rom_addr}, 32'h100);
    chk("redir_issue", {31'd0, rom_en}, 1);
    drain(20);

    // Wrap-around through 16'hFFFF
    repeat (2) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    q.delete();
    push_run(16'hFFFE, 4);
    cyc();
    redirect_valid = 1'b0;
    drain(20);

    // fetch_en low: buffer drains, then resumes
    repeat (2) cyc();
    fetch_en = 1'b0;
    push_run(16'h0002, 2);
    @(negedge clk);
    chk("fe_low_rom_en", {31'd0, rom_en}, 0);
    drain(20);
    cyc();
    @(negedge clk);
    chk("fe_low_nvalid", {31'd0, inst_valid}, 0);
    chk("fe_low_rom_en2", {31'd0, rom_en}, 0);
    cyc();
    fetch_en = 1'b1;
    push_run(16'h0004, 2);
    cyc();
    @(negedge clk);
    chk("resume_addr", {16'h0, rom_addr}, 32'd4);
    chk("resume_issue", {31'd0, rom_en}, 1);
    drain(20);

    // Reset dominates redirect with full buffer
    repeat (2) cyc();
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0055;
    inst_ready = 1'b1;
    q.delete();
    cyc();
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rst2_nvalid", {31'd0, inst_valid}, 0);
    chk("rst2_rom_en", {31'd0, rom_en}, 0);
    push_run(16'h0000, 2);
    cyc();
    @(negedge clk);
    chk("rst2_addr", {16'h0, rom_addr}, 0);
    chk("rst2_issue", {31'd0, rom_en}, 1);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
